// File: rtl/bfm_apb_pkg.sv
// Shared types for the BFM APB bridge: FSM state encoding and a clog2 helper.
package bfm_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  // Ceiling log2; returns 0 for inputs of 0 or 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bfm_apb_timeout.sv
// ACCESS-cycle watchdog for the BFM APB bridge; only compiled when
// BFM_APB_BRIDGE_TIMEOUT_EN is defined.
`ifdef BFM_APB_BRIDGE_TIMEOUT_EN
module bfm_apb_timeout
  import bfm_apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CNT_W = (clog2(TIMEOUT_CYCLES) > 0) ? clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt;

  // Counts completed ACCESS cycles; the current cycle is number cnt+1.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired_c = en && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/bfm_apb2apb_bridge_param.sv
// Single-clock APB3 slave-to-master bridge with one-hot slave decode.
// Optional downstream hang protection under BFM_APB_BRIDGE_TIMEOUT_EN.
module bfm_apb2apb_bridge_param
  import bfm_apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_SLAVES     = 16,
  parameter int unsigned SEL_LSB        = 24,
  parameter int unsigned SEL_BITS       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TPD            = 1
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL_PM,
  input  logic [ADDR_WIDTH-1:0] PADDR_PM,
  input  logic                  PWRITE_PM,
  input  logic                  PENABLE_PM,
  input  logic [DATA_WIDTH-1:0] PWDATA_PM,
  output logic [DATA_WIDTH-1:0] PRDATA_PM,
  output logic                  PREADY_PM,
  output logic                  PSLVERR_PM,
  output logic [NUM_SLAVES-1:0] PSEL_SC,
  output logic [ADDR_WIDTH-1:0] PADDR_SC,
  output logic                  PWRITE_SC,
  output logic                  PENABLE_SC,
  output logic [DATA_WIDTH-1:0] PWDATA_SC,
  input  logic [DATA_WIDTH-1:0] PRDATA_SC,
  input  logic                  PREADY_SC,
  input  logic                  PSLVERR_SC
);

  // Elaboration-time parameter sanity; TPD is a bench-side delay and has no RTL effect.
  if (NUM_SLAVES < 1 || 64'(NUM_SLAVES) > (64'd1 << SEL_BITS)) begin : g_chk_slaves
    $error("NUM_SLAVES out of range for SEL_BITS");
  end
  if (SEL_LSB + SEL_BITS > ADDR_WIDTH) begin : g_chk_sel
    $error("slave-index field exceeds ADDR_WIDTH");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_chk_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  if (TPD > 1000) begin : g_chk_tpd
    $error("TPD unreasonably large");
  end

  apb_state_e state, state_nxt;

  logic [SEL_BITS-1:0]   idx_c;
  logic                  hit_c;
  logic                  timeout_c;

  logic [DATA_WIDTH-1:0] prdata_pm_nxt;
  logic                  pready_pm_nxt;
  logic                  pslverr_pm_nxt;
  logic [NUM_SLAVES-1:0] psel_sc_nxt;
  logic [ADDR_WIDTH-1:0] paddr_sc_nxt;
  logic                  pwrite_sc_nxt;
  logic                  penable_sc_nxt;
  logic [DATA_WIDTH-1:0] pwdata_sc_nxt;

  assign idx_c = PADDR_PM[SEL_LSB +: SEL_BITS];
  assign hit_c = 32'(idx_c) < NUM_SLAVES;

`ifdef BFM_APB_BRIDGE_TIMEOUT_EN
  bfm_apb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (PCLK),
    .rst      (PRESET),
    .clr      (state != ACCESS),
    .en       (state == ACCESS),
    .expired_c(timeout_c)
  );
`else
  assign timeout_c = 1'b0;
`endif

  // State and output registers.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state      <= IDLE;
      PRDATA_PM  <= '0;
      PREADY_PM  <= 1'b0;
      PSLVERR_PM <= 1'b0;
      PSEL_SC    <= '0;
      PADDR_SC   <= '0;
      PWRITE_SC  <= 1'b0;
      PENABLE_SC <= 1'b0;
      PWDATA_SC  <= '0;
    end else begin
      state      <= state_nxt;
      PRDATA_PM  <= prdata_pm_nxt;
      PREADY_PM  <= pready_pm_nxt;
      PSLVERR_PM <= pslverr_pm_nxt;
      PSEL_SC    <= psel_sc_nxt;
      PADDR_SC   <= paddr_sc_nxt;
      PWRITE_SC  <= pwrite_sc_nxt;
      PENABLE_SC <= penable_sc_nxt;
      PWDATA_SC  <= pwdata_sc_nxt;
    end
  end

  // Next-state and next-output logic; response fields hold between transfers.
  always_comb begin
    state_nxt      = state;
    prdata_pm_nxt  = PRDATA_PM;
    pready_pm_nxt  = 1'b0;
    pslverr_pm_nxt = PSLVERR_PM;
    psel_sc_nxt    = PSEL_SC;
    paddr_sc_nxt   = PADDR_SC;
    pwrite_sc_nxt  = PWRITE_SC;
    penable_sc_nxt = PENABLE_SC;
    pwdata_sc_nxt  = PWDATA_SC;

    case (state)
      IDLE: begin
        if (PSEL_PM && !PENABLE_PM) begin
          if (hit_c) begin
            state_nxt      = SETUP;
            psel_sc_nxt    = NUM_SLAVES'(1) << idx_c;
            paddr_sc_nxt   = PADDR_PM;
            pwrite_sc_nxt  = PWRITE_PM;
            pwdata_sc_nxt  = PWDATA_PM;
            penable_sc_nxt = 1'b0;
          end else begin
            state_nxt      = RESP;
            pready_pm_nxt  = 1'b1;
            pslverr_pm_nxt = 1'b1;
            prdata_pm_nxt  = '0;
          end
        end
      end
      SETUP: begin
        state_nxt      = ACCESS;
        penable_sc_nxt = 1'b1;
      end
      ACCESS: begin
        // A real slave response takes priority over a same-cycle timeout.
        if (PREADY_SC || timeout_c) begin
          state_nxt      = RESP;
          pready_pm_nxt  = 1'b1;
          psel_sc_nxt    = '0;
          paddr_sc_nxt   = '0;
          pwrite_sc_nxt  = 1'b0;
          penable_sc_nxt = 1'b0;
          pwdata_sc_nxt  = '0;
          if (PREADY_SC) begin
            prdata_pm_nxt  = PWRITE_SC ? '0 : PRDATA_SC;
            pslverr_pm_nxt = PSLVERR_SC;
          end else begin
            prdata_pm_nxt  = '0;
            pslverr_pm_nxt = 1'b1;
          end
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bfm_apb2apb_bridge_param.sv
// Directed bench for bfm_apb2apb_bridge_param; covers both builds of BFM_APB_BRIDGE_TIMEOUT_EN.
module tb_bfm_apb2apb_bridge_param;

  logic        PCLK = 1'b0;
  logic        PRESET;

  logic        PSEL_PM, PWRITE_PM, PENABLE_PM;
  logic [31:0] PADDR_PM, PWDATA_PM;
  logic [31:0] PRDATA_PM;
  logic        PREADY_PM, PSLVERR_PM;
  logic [15:0] PSEL_SC;
  logic [31:0] PADDR_SC, PWDATA_SC;
  logic        PWRITE_SC, PENABLE_SC;
  logic [31:0] PRDATA_SC;
  logic        PREADY_SC, PSLVERR_SC;

  logic        PSEL_PM4, PWRITE_PM4, PENABLE_PM4;
  logic [31:0] PADDR_PM4, PWDATA_PM4;
  logic [31:0] PRDATA_PM4;
  logic        PREADY_PM4, PSLVERR_PM4;
  logic [3:0]  PSEL_SC4;
  logic [31:0] PADDR_SC4, PWDATA_SC4;
  logic        PWRITE_SC4, PENABLE_SC4;
  logic [31:0] PRDATA_SC4;
  logic        PREADY_SC4, PSLVERR_SC4;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  always #5 PCLK = ~PCLK;

  bfm_apb2apb_bridge_param #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .PSEL_PM(PSEL_PM), .PADDR_PM(PADDR_PM), .PWRITE_PM(PWRITE_PM),
    .PENABLE_PM(PENABLE_PM), .PWDATA_PM(PWDATA_PM),
    .PRDATA_PM(PRDATA_PM), .PREADY_PM(PREADY_PM), .PSLVERR_PM(PSLVERR_PM),
    .PSEL_SC(PSEL_SC), .PADDR_SC(PADDR_SC), .PWRITE_SC(PWRITE_SC),
    .PENABLE_SC(PENABLE_SC), .PWDATA_SC(PWDATA_SC),
    .PRDATA_SC(PRDATA_SC), .PREADY_SC(PREADY_SC), .PSLVERR_SC(PSLVERR_SC)
  );

  bfm_apb2apb_bridge_param #(
    .NUM_SLAVES(4)
  ) dut4 (
    .PCLK(PCLK), .PRESET(PRESET),
    .PSEL_PM(PSEL_PM4), .PADDR_PM(PADDR_PM4), .PWRITE_PM(PWRITE_PM4),
    .PENABLE_PM(PENABLE_PM4), .PWDATA_PM(PWDATA_PM4),
    .PRDATA_PM(PRDATA_PM4), .PREADY_PM(PREADY_PM4), .PSLVERR_PM(PSLVERR_PM4),
    .PSEL_SC(PSEL_SC4), .PADDR_SC(PADDR_SC4), .PWRITE_SC(PWRITE_SC4),
    .PENABLE_SC(PENABLE_SC4), .PWDATA_SC(PWDATA_SC4),
    .PRDATA_SC(PRDATA_SC4), .PREADY_SC(PREADY_SC4), .PSLVERR_SC(PSLVERR_SC4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic pm_setup(input logic [31:0] a, input logic w, input logic [31:0] d);
    PSEL_PM    = 1'b1;
    PENABLE_PM = 1'b0;
    PADDR_PM   = a;
    PWRITE_PM  = w;
    PWDATA_PM  = d;
  endtask

  task automatic pm4_setup(input logic [31:0] a, input logic w, input logic [31:0] d);
    PSEL_PM4    = 1'b1;
    PENABLE_PM4 = 1'b0;
    PADDR_PM4   = a;
    PWRITE_PM4  = w;
    PWDATA_PM4  = d;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESET = 1'b1;
    PSEL_PM = 1'b0; PENABLE_PM = 1'b0; PWRITE_PM = 1'b0; PADDR_PM = '0; PWDATA_PM = '0;
    PRDATA_SC = '0; PREADY_SC = 1'b0; PSLVERR_SC = 1'b0;
    PSEL_PM4 = 1'b0; PENABLE_PM4 = 1'b0; PWRITE_PM4 = 1'b0; PADDR_PM4 = '0; PWDATA_PM4 = '0;
    PRDATA_SC4 = '0; PREADY_SC4 = 1'b0; PSLVERR_SC4 = 1'b0;
    tick();
    tick();
    check("rst_pready",  64'(PREADY_PM),  64'h0);
    check("rst_pslverr", 64'(PSLVERR_PM), 64'h0);
    check("rst_prdata",  64'(PRDATA_PM),  64'h0);
    check("rst_psel",    64'(PSEL_SC),    64'h0);
    check("rst_penable", 64'(PENABLE_SC), 64'h0);
    check("rst4_pready", 64'(PREADY_PM4), 64'h0);
    PRESET = 1'b0;

    // Write, zero-wait; PREADY_SC already high in SETUP must be ignored.
    PREADY_SC = 1'b1; PSLVERR_SC = 1'b0; PRDATA_SC = 32'hFFFF_FFFF;
    pm_setup(32'h0300_0010, 1'b1, 32'hA5A5_5A5A);
    tick();  // T1 SETUP
    check("t1_psel",    64'(PSEL_SC),    64'h0008);
    check("t1_penable", 64'(PENABLE_SC), 64'h0);
    check("t1_pwrite",  64'(PWRITE_SC),  64'h1);
    check("t1_pwdata",  64'(PWDATA_SC),  64'hA5A5_5A5A);
    check("t1_paddr",   64'(PADDR_SC),   64'h0300_0010);
    PENABLE_PM = 1'b1;
    tick();  // T2 ACCESS
    check("t1_penable_acc", 64'(PENABLE_SC), 64'h1);
    check("t1_pready_t2",   64'(PREADY_PM),  64'h0);
    tick();  // T3 RESP
    check("t1_pready",    64'(PREADY_PM),  64'h1);
    check("t1_pslverr",   64'(PSLVERR_PM), 64'h0);
    check("t1_prdata",    64'(PRDATA_PM),  64'h0);
    check("t1_psel_clr",  64'(PSEL_SC),    64'h0);
    check("t1_paddr_clr", 64'(PADDR_SC),   64'h0);
    check("t1_pwrite_clr",64'(PWRITE_SC),  64'h0);
    PSEL_PM = 1'b0; PENABLE_PM = 1'b0;
    tick();
    check("t1_pready_pulse", 64'(PREADY_PM), 64'h0);

    // Read with two downstream wait states.
    PREADY_SC = 1'b0; PRDATA_SC = 32'h1234_5678;
    pm_setup(32'h0500_0004, 1'b0, 32'h0);
    tick();  // T1
    check("t2_psel",   64'(PSEL_SC),   64'h0020);
    check("t2_pwrite", 64'(PWRITE_SC), 64'h0);
    PENABLE_PM = 1'b1;
    tick();  // T2
    tick();  // T3
    check("t2_wait1_pready",  64'(PREADY_PM),  64'h0);
    check("t2_wait1_penable", 64'(PENABLE_SC), 64'h1);
    tick();  // T4
    check("t2_wait2_pready", 64'(PREADY_PM), 64'h0);
    PREADY_SC = 1'b1;
    tick();  // T5
    check("t2_pready",  64'(PREADY_PM),  64'h1);
    check("t2_prdata",  64'(PRDATA_PM),  64'h1234_5678);
    check("t2_pslverr", 64'(PSLVERR_PM), 64'h0);
    PSEL_PM = 1'b0; PENABLE_PM = 1'b0; PREADY_SC = 1'b0;
    tick();
    check("t2_pready_off", 64'(PREADY_PM), 64'h0);
    check("t2_prdata_hold", 64'(PRDATA_PM), 64'h1234_5678);

    // NUM_SLAVES=4: last decodable slave, then an undecoded index.
    PREADY_SC4 = 1'b1; PRDATA_SC4 = 32'hDEAD_BEEF; PSLVERR_SC4 = 1'b0;
    pm4_setup(32'h0300_0000, 1'b0, 32'h0000_0055);
    tick();
    check("t3_psel_hi",  64'(PSEL_SC4),    64'h8);
    check("t3_paddr",    64'(PADDR_SC4),   64'h0300_0000);
    check("t3_pwrite",   64'(PWRITE_SC4),  64'h0);
    check("t3_pwdata",   64'(PWDATA_SC4),  64'h55);
    check("t3_penable0", 64'(PENABLE_SC4), 64'h0);
    PENABLE_PM4 = 1'b1;
    tick();
    tick();
    check("t3_pready_ok", 64'(PREADY_PM4), 64'h1);
    check("t3_prdata_ok", 64'(PRDATA_PM4), 64'hDEAD_BEEF);
    PSEL_PM4 = 1'b0; PENABLE_PM4 = 1'b0;
    tick();
    pm4_setup(32'h0700_0000, 1'b0, 32'h0);
    tick();  // T1
    check("t3_pready",  64'(PREADY_PM4),  64'h1);
    check("t3_pslverr", 64'(PSLVERR_PM4), 64'h1);
    check("t3_prdata",  64'(PRDATA_PM4),  64'h0);
    check("t3_psel",    64'(PSEL_SC4),    64'h0);
    PENABLE_PM4 = 1'b1;
    tick();
    check("t3_pready_off", 64'(PREADY_PM4),  64'h0);
    check("t3_no_access",  64'(PENABLE_SC4), 64'h0);
    check("t3_no_sel",     64'(PSEL_SC4),    64'h0);
    PSEL_PM4 = 1'b0; PENABLE_PM4 = 1'b0;
    tick();

    // Slave error, then a clean read to the top index with upstream dropping PSEL early.
    PREADY_SC = 1'b1; PSLVERR_SC = 1'b1;
    pm_setup(32'h0000_0000, 1'b1, 32'h1111_2222);
    tick();
    check("t4_psel", 64'(PSEL_SC), 64'h0001);
    PENABLE_PM = 1'b1;
    tick();
    tick();
    check("t4_pready",  64'(PREADY_PM),  64'h1);
    check("t4_pslverr", 64'(PSLVERR_PM), 64'h1);
    PSEL_PM = 1'b0; PENABLE_PM = 1'b0;
    tick();
    check("t4_pslverr_hold", 64'(PSLVERR_PM), 64'h1);
    PSLVERR_SC = 1'b0; PRDATA_SC = 32'hCAFE_F00D;
    pm_setup(32'h0F00_0100, 1'b0, 32'h0);
    tick();
    check("t4_psel_top", 64'(PSEL_SC), 64'h8000);
    PSEL_PM = 1'b0;
    tick();
    tick();
    check("t4_clean_pready",  64'(PREADY_PM),  64'h1);
    check("t4_clean_pslverr", 64'(PSLVERR_PM), 64'h0);
    check("t4_clean_prdata",  64'(PRDATA_PM),  64'hCAFE_F00D);
    tick();

    // Hung slave.
    PREADY_SC = 1'b0;
    pm_setup(32'h0100_0000, 1'b0, 32'h0);
    tick();  // T1
    PSEL_PM = 1'b0;
    tick();  // T2, first ACCESS cycle
`ifdef BFM_APB_BRIDGE_TIMEOUT_EN
    for (int i = 0; i < 7; i++) tick();
    check("t5_acc8_penable", 64'(PENABLE_SC), 64'h1);
    check("t5_acc8_pready",  64'(PREADY_PM),  64'h0);
    tick();
    check("t5_to_pready",  64'(PREADY_PM),  64'h1);
    check("t5_to_pslverr", 64'(PSLVERR_PM), 64'h1);
    check("t5_to_prdata",  64'(PRDATA_PM),  64'h0);
    check("t5_to_psel",    64'(PSEL_SC),    64'h0);
    check("t5_to_penable", 64'(PENABLE_SC), 64'h0);
    tick();
    // Re-enter ACCESS for the reset case.
    pm_setup(32'h0200_0000, 1'b1, 32'h7777_0000);
    tick();
    PSEL_PM = 1'b0;
    tick();
`else
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        tick();
        if (PREADY_PM !== 1'b0) seen = 1'b1;
      end
      check("t5_hang_pready", 64'(seen), 64'h0);
      check("t5_hang_psel",   64'(PSEL_SC), 64'h0002);
    end
`endif

    // Reset while in ACCESS.
    check("t6_in_access", 64'(PENABLE_SC), 64'h1);
    PRESET = 1'b1;
    tick();
    check("t6_pready",  64'(PREADY_PM),  64'h0);
    check("t6_pslverr", 64'(PSLVERR_PM), 64'h0);
    check("t6_prdata",  64'(PRDATA_PM),  64'h0);
    check("t6_psel",    64'(PSEL_SC),    64'h0);
    check("t6_penable", 64'(PENABLE_SC), 64'h0);
    check("t6_paddr",   64'(PADDR_SC),   64'h0);
    check("t6_pwrite",  64'(PWRITE_SC),  64'h0);
    check("t6_pwdata",  64'(PWDATA_SC),  64'h0);
    PRESET = 1'b0;
    PREADY_SC = 1'b1; PSLVERR_SC = 1'b0;
    pm_setup(32'h0400_0008, 1'b1, 32'h0BAD_F00D);
    tick();
    check("t6_post_psel",   64'(PSEL_SC),   64'h0010);
    check("t6_post_pwdata", 64'(PWDATA_SC), 64'h0BAD_F00D);
    PENABLE_PM = 1'b1;
    tick();
    tick();
    check("t6_post_pready",  64'(PREADY_PM),  64'h1);
    check("t6_post_pslverr", 64'(PSLVERR_PM), 64'h0);
    PSEL_PM = 1'b0; PENABLE_PM = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
